pipe_stage_skid: RTL
====================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised pipeline stage register: successor to the fixed-width IF/ID enable register.
//  Carries an arbitrary DATA_W payload (e.g. {pc, pc_four, instr} = 96 b) with a valid/ready
//  handshake, a 2-entry skid buffer for full throughput under back-pressure, synchronous flush
//  with NOP injection, and a saturating back-pressure stall counter. Drops in between any two stages.
// PARAMETERS
//  DATA_W     96                     payload width, >= 1
//  RST_DATA   {DATA_W{1'b0}}         o_data value after reset
//  NOP_DATA   {{DATA_W-32{1'b0}},32'h0000_0013}  o_data value after flush (addi x0,x0,0 in low word)
//  STAT_W     16                     width of stall counter, >= 1
// PORTS
//  i_clk          in   1        clock, all state on rising edge
//  i_rst          in   1        synchronous reset, active-high
//  i_flush        in   1        synchronous flush (kill contents), active-high
//  i_valid        in   1        upstream payload valid
//  o_ready        out  1        stage can accept (upstream fire = i_valid & o_ready)
//  i_data         in   DATA_W   upstream payload
//  o_valid        out  1        downstream payload valid
//  i_ready        in   1        downstream accepts (downstream fire = o_valid & i_ready)
//  o_data         out  DATA_W   downstream payload
//  o_count        out  2        occupancy 0..2
//  o_stall_cnt    out  STAT_W   cycles with o_valid & !i_ready, saturating
// BEHAVIOUR
//  - Storage: main reg (drives o_data) + skid reg. States EMPTY(0), ONE(1), TWO(2); o_count = state.
//  - o_valid = (state != EMPTY); o_ready = (state != TWO) & !i_rst. Both purely from registered state.
//  - Priority per edge: i_rst > i_flush > handshake.
//  - Reset: state EMPTY, o_data=RST_DATA, skid=RST_DATA, o_stall_cnt=0. o_ready=0 while i_rst high.
//  - Flush: state EMPTY, o_data=NOP_DATA, skid cleared; any upstream fire in the flush cycle is
//    discarded; o_stall_cnt unaffected. Flush while EMPTY still loads NOP_DATA.
//  - EMPTY: in-fire -> main<=i_data, ONE. Else stay; o_data holds last value.
//  - ONE:  in&out fire -> main<=i_data, stay ONE; out only -> EMPTY (o_data holds);
//          in only -> skid<=i_data, TWO; neither -> stay, o_data stable.
//  - TWO:  o_ready=0; out fire -> main<=skid, ONE; else hold both.
//  - Latency: i_data accepted at edge N appears on o_data after edge N (1 cycle) when stage empty
//    or draining; throughput 1 item/cycle with i_ready held high.
//  - Ordering strictly FIFO; no item duplicated or dropped except by flush.
//  - o_data must not change while o_valid & !i_ready (except via flush/reset).
//  - Stall counter: +1 each edge where o_valid & !i_ready & !i_flush; holds at 2**STAT_W-1;
//    cleared only by i_rst.
// TESTING
//  1 Reset: i_rst=1 two cycles -> o_valid=0, o_ready=0, o_data=0, o_count=0, o_stall_cnt=0;
//    after release o_ready=1.
//  2 Stream: i_ready=1, send 0x1..0x8 back-to-back -> o_data 0x1..0x8 one cycle later each,
//    o_count never >1, o_ready stays 1.
//  3 Back-pressure: load A,B with i_ready=0 -> o_count=2, o_ready=0, o_data=A held;
//    raise i_ready -> A then B out in order, o_stall_cnt equals stalled cycles.
//  4 Flush in TWO with i_valid=1 same cycle -> next cycle o_valid=0, o_count=0,
//    o_data=NOP_DATA (low word 0x00000013); flushed input never appears.
//  5 Saturation (STAT_W=3): hold o_valid & !i_ready 12 cycles -> o_stall_cnt=7, stays 7; flush
//    keeps 7; reset -> 0.
//  6 Reset mid-operation in TWO -> next cycle EMPTY, o_data=RST_DATA, stored items lost.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a valid/ready handshake, a 2-entry skid buffer,
// synchronous flush with NOP injection and a saturating back-pressure stall counter.
module pipe_stage_skid #(
    parameter int                 DATA_W   = 96,
    parameter logic [DATA_W-1:0]  RST_DATA = '0,
    parameter logic [DATA_W-1:0]  NOP_DATA = DATA_W'(32'h0000_0013),
    parameter int                 STAT_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_count,
    output logic [STAT_W-1:0] o_stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic [STAT_W-1:0] stall_q;
    logic [STAT_W-1:0] stall_d;
    logic              in_fire;
    logic              out_fire;

    // Handshake: a transfer happens on an edge where valid and ready are both high;
    // valid never depends on ready, and o_valid/o_ready come only from registered state.
    assign o_valid     = (state_q != EMPTY);
    assign o_ready     = (state_q != TWO) && !i_rst;
    assign o_data      = main_q;
    assign o_count     = state_q;
    assign o_stall_cnt = stall_q;

    assign in_fire  = i_valid && o_ready;
    assign out_fire = o_valid && i_ready;

    always_comb begin
        stall_d = stall_q;
        if (o_valid && !i_ready && !i_flush && (stall_q != {STAT_W{1'b1}})) begin
            stall_d = stall_q + STAT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= EMPTY;
            main_q  <= RST_DATA;
            skid_q  <= RST_DATA;
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
            if (i_flush) begin
                state_q <= EMPTY;
                main_q  <= NOP_DATA;
                skid_q  <= '0;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (in_fire) begin
                            main_q  <= i_data;
                            state_q <= ONE;
                        end
                    end
                    ONE: begin
                        if (in_fire && out_fire) begin
                            main_q <= i_data;
                        end else if (out_fire) begin
                            state_q <= EMPTY;
                        end else if (in_fire) begin
                            skid_q  <= i_data;
                            state_q <= TWO;
                        end
                    end
                    TWO: begin
                        // Upstream is blocked here, so only a drain can move data.
                        if (out_fire) begin
                            main_q  <= skid_q;
                            state_q <= ONE;
                        end
                    end
                    default: begin
                        state_q <= EMPTY;
                    end
                endcase
            end
        end
    end

endmodule
